tri_scheduler: RTL and testbench

- Sequences the ray/triangle intersection datapath that feeds the hit accumulator.
- Takes one ray from the ray FIFO and fetches every triangle 0..NUM_TRI-1 from the synchronous triangle ROM.
- Writes one {ray, triangle vertices, triangle_ID} packet per triangle into the intersection-unit FIFO.
- Emits triangle_ID 0 first for every ray; downstream uses that packet as the ray-start / flush marker.

---
 rtl/tri_scheduler_if.sv | 59 +++++
 rtl/tri_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_tri_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_scheduler_if.sv
// -----------------------------------------------------------------------------
// tri_scheduler_if
//   Bundles the three buses around the triangle scheduler:
//     ray FIFO side      : in_empty, in_rd_en, ray_origin, ray_dir
//     triangle ROM side  : tri_rd_en, tri_addr, tri_v0..2
//     intersection FIFO  : out_full, out_wr_en, out_origin, out_dir,
//                          out_v0..2, out_triangle_ID
//     status             : busy, ray_count
//   Every 3-vector is packed as [2:0][D_BITS-1:0]; lane 0 is x, lane 2 is z.
//   Each lane is a signed fixed-point coordinate that the scheduler only
//   moves around, so no arithmetic depends on the signedness here.
//   modport master : the scheduler itself
//   modport slave  : the surrounding FIFOs / ROM
// -----------------------------------------------------------------------------
interface tri_scheduler_if #(
  parameter int D_BITS = 32,
  parameter int M_BITS = 12
);
  logic                    in_empty;
  logic                    in_rd_en;
  logic [2:0][D_BITS-1:0]  ray_origin;
  logic [2:0][D_BITS-1:0]  ray_dir;

  logic                    tri_rd_en;
  logic [M_BITS-1:0]       tri_addr;
  logic [2:0][D_BITS-1:0]  tri_v0;
  logic [2:0][D_BITS-1:0]  tri_v1;
  logic [2:0][D_BITS-1:0]  tri_v2;

  logic                    out_full;
  logic                    out_wr_en;
  logic [2:0][D_BITS-1:0]  out_origin;
  logic [2:0][D_BITS-1:0]  out_dir;
  logic [2:0][D_BITS-1:0]  out_v0;
  logic [2:0][D_BITS-1:0]  out_v1;
  logic [2:0][D_BITS-1:0]  out_v2;
  logic [M_BITS-1:0]       out_triangle_ID;

  logic                    busy;
  logic [15:0]             ray_count;

  modport master (
    input  in_empty, ray_origin, ray_dir,
    input  tri_v0, tri_v1, tri_v2,
    input  out_full,
    output in_rd_en, tri_rd_en, tri_addr,
    output out_wr_en, out_origin, out_dir, out_v0, out_v1, out_v2,
    output out_triangle_ID, busy, ray_count
  );

  modport slave (
    output in_empty, ray_origin, ray_dir,
    output tri_v0, tri_v1, tri_v2,
    output out_full,
    input  in_rd_en, tri_rd_en, tri_addr,
    input  out_wr_en, out_origin, out_dir, out_v0, out_v1, out_v2,
    input  out_triangle_ID, busy, ray_count
  );
endinterface

// File: rtl/tri_scheduler.sv
// -----------------------------------------------------------------------------
// tri_scheduler
//   Pops one ray from the show-ahead ray FIFO, walks triangles 0..NUM_TRI-1
//   through the synchronous triangle ROM and writes one
//   {ray, v0, v1, v2, triangle_ID} packet per triangle into the
//   intersection FIFO. ID 0 always leads a ray; downstream treats it as the
//   ray-start / flush marker.
//
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : tri_scheduler_if.master (ray FIFO, triangle ROM, output FIFO,
//           busy, ray_count)
//
// Optional feature (macro TRI_SCHED_FLUSH_EN):
//   After a ray completes, if the ray FIFO then stays empty for IDLE_FLUSH
//   consecutive IDLE cycles, one all-zero ID-0 packet is written so the
//   accumulator releases the result of the last ray. Without the macro the
//   block simply waits in IDLE.
//
// All outputs are registered. Per triangle the sequence is
// FETCH -> WAIT -> CAPTURE -> EMIT -> NEXT, i.e. 5 cycles when out_full=0.
// -----------------------------------------------------------------------------
module tri_scheduler #(
  parameter int D_BITS     = 32,
  parameter int M_BITS     = 12,
  parameter int NUM_TRI    = 1024,
  parameter int IDLE_FLUSH = 16
) (
  input logic             clock,
  input logic             reset,
  tri_scheduler_if.master bus
);

  // Elaboration-time parameter range guards.
  if (NUM_TRI < 1 || NUM_TRI > (1 << M_BITS)) begin : g_bad_num_tri
    $error("tri_scheduler: NUM_TRI out of range 1..2^M_BITS");
  end
  if (IDLE_FLUSH < 1 || IDLE_FLUSH > 65535) begin : g_bad_idle_flush
    $error("tri_scheduler: IDLE_FLUSH out of range 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    FETCH   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    EMIT    = 3'd5,
    NEXT    = 3'd6
  } state_t;

  localparam logic [M_BITS-1:0] LAST_IDX = M_BITS'(NUM_TRI - 1);

  state_t            state_reg;
  logic [M_BITS-1:0] idx_reg;

`ifdef TRI_SCHED_FLUSH_EN
  localparam logic [15:0] FLUSH_LAST = 16'(IDLE_FLUSH - 1);
  // pending_reg: the last completed ray has not yet been followed by an
  // ID-0 packet. idle_cnt_reg: consecutive empty IDLE cycles seen before
  // the current one, saturating at IDLE_FLUSH-1.
  logic              pending_reg;
  logic [15:0]       idle_cnt_reg;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg           <= IDLE;
      idx_reg             <= '0;
      bus.in_rd_en        <= 1'b0;
      bus.tri_rd_en       <= 1'b0;
      bus.tri_addr        <= '0;
      bus.out_wr_en       <= 1'b0;
      bus.out_origin      <= '0;
      bus.out_dir         <= '0;
      bus.out_v0          <= '0;
      bus.out_v1          <= '0;
      bus.out_v2          <= '0;
      bus.out_triangle_ID <= '0;
      bus.busy            <= 1'b0;
      bus.ray_count       <= '0;
`ifdef TRI_SCHED_FLUSH_EN
      pending_reg         <= 1'b0;
      idle_cnt_reg        <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // Only a flush can raise out_wr_en in IDLE; keep it a single pulse.
          bus.out_wr_en <= 1'b0;
          if (!bus.in_empty) begin
            bus.in_rd_en <= 1'b1;
            bus.busy     <= 1'b1;
            state_reg    <= LATCH;
`ifdef TRI_SCHED_FLUSH_EN
            pending_reg  <= 1'b0;
            idle_cnt_reg <= '0;
          end else if (pending_reg) begin
            // Current cycle is empty too, so a count of IDLE_FLUSH-1 means
            // IDLE_FLUSH consecutive empty cycles including this one.
            if (idle_cnt_reg >= FLUSH_LAST) begin
              if (!bus.out_full) begin
                bus.out_wr_en       <= 1'b1;
                bus.out_origin      <= '0;
                bus.out_dir         <= '0;
                bus.out_v0          <= '0;
                bus.out_v1          <= '0;
                bus.out_v2          <= '0;
                bus.out_triangle_ID <= '0;
                pending_reg         <= 1'b0;
                idle_cnt_reg        <= '0;
              end
            end else begin
              idle_cnt_reg <= idle_cnt_reg + 16'd1;
            end
`endif
          end
        end

        LATCH: begin
          // The FIFO pops on this same edge, so the head word is still
          // the ray that in_rd_en is acknowledging.
          bus.in_rd_en   <= 1'b0;
          bus.out_origin <= bus.ray_origin;
          bus.out_dir    <= bus.ray_dir;
          idx_reg        <= '0;
          state_reg      <= FETCH;
        end

        FETCH: begin
          bus.tri_rd_en <= 1'b1;
          bus.tri_addr  <= idx_reg;
          state_reg     <= WAIT;
        end

        WAIT: begin
          // ROM registers the address on this edge; data is valid next cycle.
          bus.tri_rd_en <= 1'b0;
          state_reg     <= CAPTURE;
        end

        CAPTURE: begin
          bus.out_v0          <= bus.tri_v0;
          bus.out_v1          <= bus.tri_v1;
          bus.out_v2          <= bus.tri_v2;
          bus.out_triangle_ID <= idx_reg;
          state_reg           <= EMIT;
        end

        EMIT: begin
          // Back-pressure stalls only here; packet data stays untouched.
          if (!bus.out_full) begin
            bus.out_wr_en <= 1'b1;
            state_reg     <= NEXT;
          end
        end

        NEXT: begin
          bus.out_wr_en <= 1'b0;
          if (idx_reg == LAST_IDX) begin
            bus.ray_count <= bus.ray_count + 16'd1;
            bus.busy      <= 1'b0;
            state_reg     <= IDLE;
`ifdef TRI_SCHED_FLUSH_EN
            pending_reg   <= 1'b1;
            idle_cnt_reg  <= '0;
`endif
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            state_reg <= FETCH;
          end
        end

        default: begin
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tri_scheduler
//   Two schedulers share clock/reset: dut (NUM_TRI=4) carries most scenarios,
//   dut1 (NUM_TRI=1) checks the single-triangle case with a toggling FIFO.
//   The bench models a show-ahead ray FIFO (queue), a synchronous ROM with
//   random contents, and records every write. Expected packets come from a
//   simple model: each accepted ray yields the packets
//   {ray, rom[i], i} for i = 0..NUM_TRI-1 in order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tri_scheduler;
  localparam int D_BITS     = 32;
  localparam int M_BITS     = 12;
  localparam int NT         = 4;
  localparam int IDLE_FLUSH = 16;

  typedef logic [2:0][D_BITS-1:0] vec_t;
  typedef struct {
    vec_t              o;
    vec_t              d;
    vec_t              v0;
    vec_t              v1;
    vec_t              v2;
    logic [M_BITS-1:0] id;
    int                cyc;
    logic              full_ok;
    logic              busy;
  } pkt_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  tri_scheduler_if #(.D_BITS(D_BITS), .M_BITS(M_BITS)) bus ();
  tri_scheduler_if #(.D_BITS(D_BITS), .M_BITS(M_BITS)) bus1 ();

  tri_scheduler #(.D_BITS(D_BITS), .M_BITS(M_BITS), .NUM_TRI(NT), .IDLE_FLUSH(IDLE_FLUSH))
    dut (.clock(clock), .reset(reset), .bus(bus));
  tri_scheduler #(.D_BITS(D_BITS), .M_BITS(M_BITS), .NUM_TRI(1), .IDLE_FLUSH(IDLE_FLUSH))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  // ---------------- environment models ----------------
  vec_t rom0 [NT];
  vec_t rom1 [NT];
  vec_t rom2 [NT];

  vec_t fq_o[$], fq_d[$], fq1_o[$], fq1_d[$];
  pkt_t obs_q[$], obs1_q[$], exp_q[$];
  int   rd_cyc[$];
  logic pop_req = 1'b0, pop1_req = 1'b0;
  logic full_prev = 1'b0;
  int   rd1_cnt = 0, rd1_bad = 0;
  logic [15:0] exp_rays = '0, exp1_rays = '0;

  // Synchronous ROMs: data appears the cycle after tri_rd_en.
  always @(posedge clock) begin
    if (bus.tri_rd_en) begin
      bus.tri_v0 <= (bus.tri_addr < NT) ? rom0[bus.tri_addr[1:0]] : '1;
      bus.tri_v1 <= (bus.tri_addr < NT) ? rom1[bus.tri_addr[1:0]] : '1;
      bus.tri_v2 <= (bus.tri_addr < NT) ? rom2[bus.tri_addr[1:0]] : '1;
    end
    if (bus1.tri_rd_en) begin
      bus1.tri_v0 <= (bus1.tri_addr == '0) ? rom0[0] : '1;
      bus1.tri_v1 <= (bus1.tri_addr == '0) ? rom1[0] : '1;
      bus1.tri_v2 <= (bus1.tri_addr == '0) ? rom2[0] : '1;
    end
  end

  // Values seen at the edge: in_rd_en acknowledges the head at this edge,
  // so the FIFO pops afterwards; out_full here is what EMIT sampled.
  always @(posedge clock) begin
    pop_req   <= bus.in_rd_en;
    pop1_req  <= bus1.in_rd_en;
    full_prev <= bus.out_full;
    if (bus1.in_rd_en) begin
      rd1_cnt <= rd1_cnt + 1;
      if (bus1.in_empty) rd1_bad <= rd1_bad + 1;
    end
  end

  always @(negedge clock) begin
    if (bus.out_wr_en) begin
      pkt_t p;
      p.o = bus.out_origin; p.d = bus.out_dir;
      p.v0 = bus.out_v0; p.v1 = bus.out_v1; p.v2 = bus.out_v2;
      p.id = bus.out_triangle_ID; p.cyc = cyc;
      p.full_ok = !full_prev; p.busy = bus.busy;
      obs_q.push_back(p);
      $display("write id=%0d cyc=%0d origin_x=%0h", p.id, p.cyc, p.o[0]);
    end
    if (bus1.out_wr_en) begin
      pkt_t p1;
      p1.o = bus1.out_origin; p1.d = bus1.out_dir;
      p1.v0 = bus1.out_v0; p1.v1 = bus1.out_v1; p1.v2 = bus1.out_v2;
      p1.id = bus1.out_triangle_ID; p1.cyc = cyc;
      p1.full_ok = 1'b1; p1.busy = bus1.busy;
      obs1_q.push_back(p1);
      $display("write1 id=%0d cyc=%0d origin_x=%0h", p1.id, p1.cyc, p1.o[0]);
    end
    if (bus.in_rd_en) rd_cyc.push_back(cyc);
    if (pop_req && fq_o.size() > 0) begin
      fq_o.delete(0); fq_d.delete(0);
    end
    if (pop1_req && fq1_o.size() > 0) begin
      fq1_o.delete(0); fq1_d.delete(0);
    end
    bus.in_empty    = (fq_o.size() == 0);
    bus.ray_origin  = (fq_o.size() == 0) ? '0 : fq_o[0];
    bus.ray_dir     = (fq_d.size() == 0) ? '0 : fq_d[0];
    bus1.in_empty   = (fq1_o.size() == 0);
    bus1.ray_origin = (fq1_o.size() == 0) ? '0 : fq1_o[0];
    bus1.ray_dir    = (fq1_d.size() == 0) ? '0 : fq1_d[0];
  end

  // ---------------- stimulus helpers ----------------
  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < 3; k++) v[k] = $urandom;
    return v;
  endfunction

  task automatic push_ray(input vec_t o, input vec_t d);
    fq_o.push_back(o);
    fq_d.push_back(d);
    for (int i = 0; i < NT; i++) begin
      pkt_t e;
      e.o = o; e.d = d; e.v0 = rom0[i]; e.v1 = rom1[i]; e.v2 = rom2[i];
      e.id = M_BITS'(i); e.cyc = 0; e.full_ok = 1'b1; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    exp_rays = exp_rays + 16'd1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int t = 0; t < budget && obs_q.size() < n; t++) @(negedge clock);
  endtask

  task automatic settle();
    repeat (40) @(negedge clock);
    obs_q.delete(); exp_q.delete(); rd_cyc.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (bus.in_rd_en !== 1'b0 || bus.tri_rd_en !== 1'b0 || bus.out_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got rd=%b tri=%b wr=%b want 0 0 0", bus.in_rd_en, bus.tri_rd_en, bus.out_wr_en);
    end
    checks++; if (bus.out_origin !== '0 || bus.out_dir !== '0 || bus.out_v0 !== '0 || bus.out_v1 !== '0 || bus.out_v2 !== '0) begin
      errors++; $display("FAIL reset_data got origin=%h v0=%h want 0", bus.out_origin, bus.out_v0);
    end
    checks++; if (bus.tri_addr !== '0 || bus.out_triangle_ID !== '0) begin
      errors++; $display("FAIL reset_ids got addr=%h id=%h want 0", bus.tri_addr, bus.out_triangle_ID);
    end
    checks++; if (bus.busy !== 1'b0 || bus.ray_count !== 16'd0) begin
      errors++; $display("FAIL reset_status got busy=%b ray_count=%0d want 0 0", bus.busy, bus.ray_count);
    end
  endtask

  task automatic test_single_ray();
    vec_t o, d;
    settle();
    o = '0; o[0] = 32'd1; o[1] = 32'd2; o[2] = 32'd3;
    d = '0; d[2] = {D_BITS{1'b1}};
    push_ray(o, d);
    wait_obs(NT, 300);
    checks++; if (obs_q.size() != NT) begin
      errors++; $display("FAIL single_count got %0d want %0d", obs_q.size(), NT);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i].o !== exp_q[i].o || obs_q[i].d !== exp_q[i].d || obs_q[i].v0 !== exp_q[i].v0 ||
                    obs_q[i].v1 !== exp_q[i].v1 || obs_q[i].v2 !== exp_q[i].v2 || obs_q[i].id !== exp_q[i].id ||
                    obs_q[i].busy !== 1'b1) begin
        errors++; $display("FAIL single_pkt%0d got id=%0d o=%h v0=%h want id=%0d o=%h v0=%h", i,
                           obs_q[i].id, obs_q[i].o, obs_q[i].v0, exp_q[i].id, exp_q[i].o, exp_q[i].v0);
      end
      if (i > 0) begin
        checks++; if (obs_q[i].cyc - obs_q[i-1].cyc != 5) begin
          errors++; $display("FAIL single_spacing%0d got %0d want 5", i, obs_q[i].cyc - obs_q[i-1].cyc);
        end
      end
    end
    checks++; if (rd_cyc.size() != 1 || obs_q.size() == 0 || obs_q[0].cyc - rd_cyc[0] != 5) begin
      errors++; $display("FAIL single_latency got rd_pulses=%0d first_gap=%0d want 1 5", rd_cyc.size(),
                         (rd_cyc.size() > 0 && obs_q.size() > 0) ? obs_q[0].cyc - rd_cyc[0] : -1);
    end
    repeat (2) @(negedge clock);
    checks++; if (bus.busy !== 1'b0 || bus.ray_count !== exp_rays) begin
      errors++; $display("FAIL single_done got busy=%b ray_count=%0d want 0 %0d", bus.busy, bus.ray_count, exp_rays);
    end
  endtask

  task automatic test_back_to_back();
    settle();
    push_ray(rand_vec(), rand_vec());
    push_ray(rand_vec(), rand_vec());
    wait_obs(2 * NT, 400);
    checks++; if (obs_q.size() != 2 * NT || rd_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count got writes=%0d rd=%0d want %0d 2", obs_q.size(), rd_cyc.size(), 2 * NT);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i].o !== exp_q[i].o || obs_q[i].d !== exp_q[i].d || obs_q[i].v0 !== exp_q[i].v0 ||
                    obs_q[i].v1 !== exp_q[i].v1 || obs_q[i].v2 !== exp_q[i].v2 || obs_q[i].id !== exp_q[i].id) begin
        errors++; $display("FAIL b2b_pkt%0d got id=%0d o=%h want id=%0d o=%h", i, obs_q[i].id, obs_q[i].o, exp_q[i].id, exp_q[i].o);
      end
    end
    repeat (2) @(negedge clock);
    checks++; if (bus.ray_count !== exp_rays) begin
      errors++; $display("FAIL b2b_ray_count got %0d want %0d", bus.ray_count, exp_rays);
    end
  endtask

  task automatic test_stall();
    settle();
    push_ray(rand_vec(), rand_vec());
    wait_obs(1, 100);
    bus.out_full = 1'b1;
    repeat (20) @(negedge clock);
    checks++; if (obs_q.size() != 1) begin
      errors++; $display("FAIL stall_no_write got %0d writes want 1", obs_q.size());
    end
    bus.out_full = 1'b0;
    wait_obs(NT, 200);
    checks++; if (obs_q.size() != NT) begin
      errors++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), NT);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i].id !== exp_q[i].id || obs_q[i].v0 !== exp_q[i].v0 || obs_q[i].o !== exp_q[i].o ||
                    obs_q[i].full_ok !== 1'b1) begin
        errors++; $display("FAIL stall_pkt%0d got id=%0d full_ok=%b want id=%0d full_ok=1", i, obs_q[i].id, obs_q[i].full_ok, exp_q[i].id);
      end
    end
    checks++; if (obs_q.size() < 2 || obs_q[1].cyc - obs_q[0].cyc < 20) begin
      errors++; $display("FAIL stall_gap got %0d want >=20", obs_q.size() < 2 ? -1 : obs_q[1].cyc - obs_q[0].cyc);
    end
  endtask

  task automatic test_random();
    int t;
    settle();
    for (int r = 0; r < 3; r++) push_ray(rand_vec(), rand_vec());
    t = 0;
    while (obs_q.size() < 3 * NT && t < 3000) begin
      bus.out_full = ($urandom_range(0, 2) == 0);
      @(negedge clock);
      t++;
    end
    bus.out_full = 1'b0;
    checks++; if (obs_q.size() != 3 * NT) begin
      errors++; $display("FAIL random_count got %0d want %0d", obs_q.size(), 3 * NT);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i].o !== exp_q[i].o || obs_q[i].d !== exp_q[i].d || obs_q[i].v0 !== exp_q[i].v0 ||
                    obs_q[i].v1 !== exp_q[i].v1 || obs_q[i].v2 !== exp_q[i].v2 || obs_q[i].id !== exp_q[i].id ||
                    obs_q[i].full_ok !== 1'b1) begin
        errors++; $display("FAIL random_pkt%0d got id=%0d full_ok=%b want id=%0d", i, obs_q[i].id, obs_q[i].full_ok, exp_q[i].id);
      end
    end
    repeat (2) @(negedge clock);
    checks++; if (bus.ray_count !== exp_rays) begin
      errors++; $display("FAIL random_ray_count got %0d want %0d", bus.ray_count, exp_rays);
    end
  endtask

  task automatic test_reset_mid();
    settle();
    push_ray(rand_vec(), rand_vec());
    wait_obs(2, 100);
    repeat (2) @(negedge clock);           // ID 2 now in FETCH/WAIT
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_rays = '0; exp1_rays = '0;
    checks++; if (bus.busy !== 1'b0 || bus.ray_count !== 16'd0 || bus.tri_rd_en !== 1'b0 ||
                  bus.out_triangle_ID !== '0 || bus.out_origin !== '0 || bus.out_v0 !== '0) begin
      errors++; $display("FAIL midreset_outputs got busy=%b rc=%0d id=%0d want 0 0 0", bus.busy, bus.ray_count, bus.out_triangle_ID);
    end
    repeat (10) @(negedge clock);
    checks++; if (obs_q.size() != 2) begin
      errors++; $display("FAIL midreset_abandon got %0d writes want 2", obs_q.size());
    end
    obs_q.delete(); exp_q.delete(); rd_cyc.delete();
    push_ray(rand_vec(), rand_vec());
    wait_obs(1, 100);
    checks++; if (obs_q.size() < 1 || obs_q[0].id !== '0 || obs_q[0].o !== exp_q[0].o || bus.ray_count !== 16'd0) begin
      errors++; $display("FAIL midreset_restart got n=%0d rc=%0d want first id 0 rc 0", obs_q.size(), bus.ray_count);
    end
    wait_obs(NT, 200);
    repeat (2) @(negedge clock);
    checks++; if (obs_q.size() != NT || bus.ray_count !== exp_rays) begin
      errors++; $display("FAIL midreset_finish got n=%0d rc=%0d want %0d %0d", obs_q.size(), bus.ray_count, NT, exp_rays);
    end
  endtask

  task automatic test_single_tri();
    vec_t ro[5], rd[5];
    int   base_rd, base_bad;
    base_rd = rd1_cnt; base_bad = rd1_bad;
    obs1_q.delete();
    for (int r = 0; r < 5; r++) begin
      ro[r] = rand_vec(); rd[r] = rand_vec();
      fq1_o.push_back(ro[r]); fq1_d.push_back(rd[r]);
      exp1_rays = exp1_rays + 16'd1;
      repeat ($urandom_range(0, 6)) @(negedge clock);
    end
    for (int t = 0; t < 300 && obs1_q.size() < 5; t++) @(negedge clock);
    repeat (2) @(negedge clock);
    checks++; if (obs1_q.size() != 5 || rd1_cnt - base_rd != 5 || rd1_bad != base_bad) begin
      errors++; $display("FAIL one_tri_count got writes=%0d rd=%0d bad_rd=%0d want 5 5 0",
                         obs1_q.size(), rd1_cnt - base_rd, rd1_bad - base_bad);
    end
    for (int i = 0; i < obs1_q.size() && i < 5; i++) begin
      checks++; if (obs1_q[i].id !== '0 || obs1_q[i].o !== ro[i] || obs1_q[i].d !== rd[i] || obs1_q[i].v0 !== rom0[0] ||
                    obs1_q[i].v2 !== rom2[0]) begin
        errors++; $display("FAIL one_tri_pkt%0d got id=%0d o=%h want id=0 o=%h", i, obs1_q[i].id, obs1_q[i].o, ro[i]);
      end
    end
    checks++; if (bus1.ray_count !== exp1_rays) begin
      errors++; $display("FAIL one_tri_ray_count got %0d want %0d", bus1.ray_count, exp1_rays);
    end
  endtask

  task automatic test_flush();
    int last_cyc;
    settle();
    push_ray(rand_vec(), rand_vec());
    wait_obs(NT, 200);
    last_cyc = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].cyc : 0;
    obs_q.delete();
    repeat (60) @(negedge clock);
`ifdef TRI_SCHED_FLUSH_EN
    checks++; if (obs_q.size() != 1) begin
      errors++; $display("FAIL flush_count got %0d want 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0].id !== '0 || obs_q[0].o !== '0 || obs_q[0].d !== '0 || obs_q[0].v0 !== '0 ||
                    obs_q[0].v1 !== '0 || obs_q[0].v2 !== '0) begin
        errors++; $display("FAIL flush_data got id=%0d o=%h v0=%h want all zero", obs_q[0].id, obs_q[0].o, obs_q[0].v0);
      end
      checks++; if (obs_q[0].cyc - last_cyc < IDLE_FLUSH || obs_q[0].cyc - last_cyc > IDLE_FLUSH + 2) begin
        errors++; $display("FAIL flush_delay got %0d want %0d..%0d", obs_q[0].cyc - last_cyc, IDLE_FLUSH, IDLE_FLUSH + 2);
      end
    end
`else
    checks++; if (obs_q.size() != 0) begin
      errors++; $display("FAIL flush_none got %0d writes after ray end %0d want 0", obs_q.size(), last_cyc);
    end
`endif
    checks++; if (bus.ray_count !== exp_rays) begin
      errors++; $display("FAIL flush_ray_count got %0d want %0d", bus.ray_count, exp_rays);
    end
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      rom0[i] = rand_vec(); rom1[i] = rand_vec(); rom2[i] = rand_vec();
    end
    bus.out_full  = 1'b0;
    bus1.out_full = 1'b0;
    reset = 1'b0;
    test_reset();
    reset = 1'b1;
    test_single_ray();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    test_single_tri();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
